// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU datapath widths, index/word types and register constants
//
// Purpose : common definitions for the register file and its read ports.
// Contents: DATA_WIDTH / ADDR_WIDTH defaults, reg_idx_t, word_t, ZERO_REG.
package cpu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  // Index of the architectural zero register.
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - combinational NUM_REGS:1 register read mux with zero-register masking
//
// Purpose : selects one register out of the flattened register array.
// Ports   :
//   regs_flat  in   NUM_REGS*DATA_WIDTH  all registers, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   read_idx   in   ADDR_WIDTH           register index to read
//   read_data  out  DATA_WIDTH           selected register (0 for index 0 when ZERO_REG_EN=1)
module regfile_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH  = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH  = cpu_pkg::ADDR_WIDTH,
  parameter int NUM_REGS    = 2 ** ADDR_WIDTH,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
  input  logic [ADDR_WIDTH-1:0]          read_idx,
  output logic [DATA_WIDTH-1:0]          read_data
);

  always_comb begin
    read_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (read_idx == ADDR_WIDTH'(i)) begin
        read_data = regs_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    // The array already holds zero at index 0, but masking here keeps the
    // port correct even if the storage for index 0 is ever reintroduced.
    if (ZERO_REG_EN && (read_idx == ADDR_WIDTH'(ZERO_REG))) begin
      read_data = '0;
    end
  end

endmodule

// File: rtl/register_bank.sv
// rtl/register_bank.sv - 2-read / 1-write general-purpose register file with hardwired zero register
//
// Purpose : CPU register file; combinational reads for ALU operands, one
//           synchronous writeback port, asynchronous active-high clear.
// Ports   :
//   clk           in   1           write clock (rising edge)
//   rst           in   1           async active-high reset, clears all registers, blocks writes
//   read_reg_1    in   ADDR_WIDTH  index for read port 1
//   read_reg_2    in   ADDR_WIDTH  index for read port 2
//   write_reg     in   ADDR_WIDTH  index for the write port
//   write_enable  in   1           write strobe, sampled at rising clk
//   write_data    in   DATA_WIDTH  value to store
//   read_data_1   out  DATA_WIDTH  contents of register read_reg_1
//   read_data_2   out  DATA_WIDTH  contents of register read_reg_2
module register_bank
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH  = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH  = cpu_pkg::ADDR_WIDTH,
  parameter int NUM_REGS    = 2 ** ADDR_WIDTH,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read_reg_1,
  input  logic [ADDR_WIDTH-1:0] read_reg_2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2
);

  // Whole array flattened so both read muxes share one vector.
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (ZERO_REG_EN && (i == ZERO_REG)) begin : g_zero
      // No storage: the zero register is a constant.
      assign regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end else begin : g_flop
      logic [DATA_WIDTH-1:0] reg_d;
      logic [DATA_WIDTH-1:0] reg_q;

      // An X write_enable falls to the hold branch, i.e. no write.
      always_comb begin
        reg_d = reg_q;
        if (write_enable && (write_reg == ADDR_WIDTH'(i))) begin
          reg_d = write_data;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = reg_q;
    end
  end

  // Reads come straight from the flops, so a same-cycle write shows the old
  // value until the edge (no bypass).
  regfile_read_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_REGS    (NUM_REGS),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_read_port_1 (
    .regs_flat (regs_flat),
    .read_idx  (read_reg_1),
    .read_data (read_data_1)
  );

  regfile_read_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_REGS    (NUM_REGS),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_read_port_2 (
    .regs_flat (regs_flat),
    .read_idx  (read_reg_2),
    .read_data (read_data_2)
  );

  // Simulation-only guard: an unknown strobe is silently treated as no write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!$isunknown(write_enable));
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - directed self-checking bench for register_bank
module tb_register_bank;

  logic        clk;
  logic        rst;
  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic [4:0]  write_reg;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] nz_read_data_1;
  logic [31:0] nz_read_data_2;

  int n_checks = 0;
  int n_fail   = 0;

  register_bank dut (
    .clk          (clk),
    .rst          (rst),
    .read_reg_1   (read_reg_1),
    .read_reg_2   (read_reg_2),
    .write_reg    (write_reg),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_data_1  (read_data_1),
    .read_data_2  (read_data_2)
  );

  // Same stimulus, register 0 behaves as an ordinary register.
  register_bank #(.ZERO_REG_EN(1'b0)) dut_nz (
    .clk          (clk),
    .rst          (rst),
    .read_reg_1   (read_reg_1),
    .read_reg_2   (read_reg_2),
    .write_reg    (write_reg),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_data_1  (nz_read_data_1),
    .read_data_2  (nz_read_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive a write at a falling edge; the following rising edge commits it.
  task automatic do_write(input logic [4:0] idx, input logic [31:0] data, input logic en);
    @(negedge clk);
    write_reg    = idx;
    write_data   = data;
    write_enable = en;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    read_reg_1   = 5'd1;
    read_reg_2   = 5'd2;
    write_reg    = 5'd0;
    write_enable = 1'b0;
    write_data   = 32'h0;

    @(negedge clk);
    #1;
    check("reset_rd1", read_data_1, 32'h0);
    check("reset_rd2", read_data_2, 32'h0);
    rst = 1'b0;

    // Load r2=7, then assert reset mid-cycle and expect an immediate clear.
    do_write(5'd2, 32'd7, 1'b1);
    read_reg_1 = 5'd2;
    #1;
    check("pre_reset_r2", read_data_1, 32'd7);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_r2", read_data_1, 32'h0);

    // A write attempted while reset is held must not land.
    write_reg    = 5'd4;
    write_data   = 32'd5;
    write_enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    write_enable = 1'b0;
    rst          = 1'b0;

    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      read_reg_1 = 5'(i);
      read_reg_2 = 5'(31 - i + 1);
      #1;
      check($sformatf("after_reset_p1_r%0d", i), read_data_1, 32'h0);
      check($sformatf("after_reset_p2_r%0d", 32 - i), read_data_2, 32'h0);
    end

    // Basic write and overwrite.
    do_write(5'd2, 32'd69, 1'b1);
    read_reg_1 = 5'd2;
    #1;
    check("basic_r2", read_data_1, 32'd69);
    do_write(5'd2, 32'd420, 1'b1);
    #1;
    check("overwrite_r2", read_data_1, 32'd420);

    // Dual-port independence.
    do_write(5'd5, 32'd1234, 1'b1);
    read_reg_1 = 5'd2;
    read_reg_2 = 5'd5;
    #1;
    check("dual_p1_r2", read_data_1, 32'd420);
    check("dual_p2_r5", read_data_2, 32'd1234);
    read_reg_1 = 5'd5;
    #1;
    check("same_p1_r5", read_data_1, 32'd1234);
    check("same_p2_r5", read_data_2, 32'd1234);

    // Disabled writes over several edges leave r5 alone.
    @(negedge clk);
    write_reg    = 5'd5;
    write_data   = 32'd99;
    write_enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("no_we_p1_r5", read_data_1, 32'd1234);
    check("no_we_p2_r5", read_data_2, 32'd1234);

    // Register 0: discarded with the zero register, stored without it.
    do_write(5'd0, 32'hDEADBEEF, 1'b1);
    read_reg_1 = 5'd0;
    read_reg_2 = 5'd0;
    #1;
    check("zero_p1_r0", read_data_1, 32'h0);
    check("zero_p2_r0", read_data_2, 32'h0);
    check("nz_p1_r0", nz_read_data_1, 32'hDEADBEEF);
    check("nz_p2_r0", nz_read_data_2, 32'hDEADBEEF);

    // Read-during-write: old value before the edge, new value after it.
    @(negedge clk);
    read_reg_1   = 5'd3;
    write_reg    = 5'd3;
    write_data   = 32'h55;
    write_enable = 1'b1;
    #1;
    check("rdw_before_edge", read_data_1, 32'h0);
    @(posedge clk);
    #1;
    check("rdw_after_edge", read_data_1, 32'h55);
    write_enable = 1'b0;

    // Earlier values must survive the later activity.
    @(negedge clk);
    read_reg_1 = 5'd2;
    read_reg_2 = 5'd3;
    #1;
    check("final_r2", read_data_1, 32'd420);
    check("final_r3", read_data_2, 32'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
General-purpose register file for the CPU datapath: 32 registers of 32 bits each.
- Two independent combinational read ports feed the ALU operands.
- One synchronous write port takes the writeback result.
- Register 0 is hardwired to zero, RISC-style.
- Sits between instruction decode (register indices) and execute/writeback.

Parameters:
- DATA_WIDTH, 32, bit width of each register and data port.
- ADDR_WIDTH, 5, width of register index ports.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_WIDTH.
- ZERO_REG_EN, 1, when 1, register 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears every register.
- read_reg_1  input  ADDR_WIDTH  index for read port 1.
- read_reg_2  input  ADDR_WIDTH  index for read port 2.
- write_reg  input  ADDR_WIDTH  index for the write port.
- write_enable  input  1  write strobe, sampled at the rising edge of clk.
- write_data  input  DATA_WIDTH  value to store.
- read_data_1  output  DATA_WIDTH  contents of register read_reg_1.
- read_data_2  output  DATA_WIDTH  contents of register read_reg_2.

Behaviour:
- Storage: NUM_REGS x DATA_WIDTH flip-flop array.
- Reset:
  - rst high asynchronously forces all registers to 0, so both read outputs become 0 without waiting for a clock.
  - While rst is high, writes are blocked.
  - Deassertion is synchronised by the integrator; no internal synchroniser.
- Write:
  - On posedge clk with rst low and write_enable=1, reg[write_reg] <= write_data.
  - write_enable=0: no register changes.
  - Write latency is 1 edge: the new value is visible on the read ports immediately after that edge.
- Read:
  - Purely combinational: read_data_N = reg[read_reg_N].
  - Zero-cycle latency from an index change.
  - The two ports are fully independent and may address the same register.
- Read-during-write to the same index in the same cycle: the read port shows the OLD value until the clock edge, then the new value. No write-to-read bypass.
- Register 0 (ZERO_REG_EN=1):
  - Reads of index 0 return 0.
  - Writes to index 0 are discarded; no flop is needed for index 0.
  - With ZERO_REG_EN=0, register 0 behaves like any other register.
- All indices are in range (NUM_REGS = 2**ADDR_WIDTH), so there is no out-of-range case.
- Unknown/X on write_enable: treat as no write (assert in simulation only).
- No internal state besides the array; no stall or handshake signals.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH constants.
  - typedef reg_idx_t (logic [ADDR_WIDTH-1:0]).
  - typedef word_t (logic [DATA_WIDTH-1:0]).
  - localparam ZERO_REG = 0.
- One natural sub-module: regfile_read_port, a NUM_REGS:1 DATA_WIDTH mux with zero-register masking.
  - Instantiated twice, once per read port.
  - The write decode and array stay in register_bank.

Test Plan:
- Reset: assert rst mid-cycle after loading r2=7 -> read_data_1 for read_reg_1=2 drops to 0 immediately, without a clock edge. All 31 writable registers read 0 after reset.
- Basic write/read: write_reg=2, write_data=69, write_enable=1 for one edge, then write_enable=0 and read_reg_1=2 -> read_data_1=69.
- Overwrite: write_reg=2, write_data=420, one edge with write_enable=1; read_reg_1=2 -> read_data_1=420, never 69 afterwards.
- Independence and dual port:
  - write_reg=5, write_data=1234, one enabled edge.
  - read_reg_1=2 -> read_data_1=420; read_reg_2=5 -> read_data_2=1234.
  - Both ports on index 5 -> both 1234.
- Enable and zero register:
  - write_enable=0 with write_reg=5, write_data=99 over several edges -> r5 still 1234.
  - write_reg=0, write_data=0xDEADBEEF enabled -> read index 0 returns 0.
- Read-during-write: read_reg_1=3 (value 0) while writing 0x55 to r3 -> read_data_1=0 before the edge, 0x55 right after the edge.
